// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard / forwarding unit.
package hazard_fwd_unit_pkg;

  // EX-stage operand mux selects.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int HAZ_AW_DEFAULT = 5;
  localparam int LOAD_STALL_MAX = 7;
  localparam int LD_CNT_W       = 3;

  // The youngest producer (EX/MEM) always wins over the older one (MEM/WB).
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of the hazard / forwarding unit.
// master = pipeline (drives stage info, consumes controls), slave = hazard unit.
// There is no valid/ready handshake: every signal is a per-cycle level.
// ld_cnt_dbg / busy_dbg expose the internal state for checkers.
interface hazard_fwd_unit_if
  import hazard_fwd_unit_pkg::*;
#(
  parameter int AW      = HAZ_AW_DEFAULT,
  parameter int NUM_SRC = 2
);
  localparam int NREG = 2 ** AW;

  logic [NUM_SRC*AW-1:0] id_rs;
  logic [NUM_SRC-1:0]    id_rs_used;
  logic [AW-1:0]         id_rd;
  logic                  id_rw;
  logic [NUM_SRC*AW-1:0] id_ex_rs;
  logic [AW-1:0]         id_ex_rd;
  logic                  id_ex_mem_read;
  logic [AW-1:0]         ex_mem_rd;
  logic                  ex_mem_rw;
  logic [AW-1:0]         mem_wb_rd;
  logic                  mem_wb_rw;
  logic                  md_issue;
  logic [AW-1:0]         md_rd;
  logic                  md_done;
  logic [AW-1:0]         md_done_rd;
  logic                  branch_taken;

  logic [2*NUM_SRC-1:0]  fwd_sel;
  logic                  stall;
  logic                  flush_id_ex;
  logic                  flush_if_id;
  logic [31:0]           stall_cycles;
  logic [LD_CNT_W-1:0]   ld_cnt_dbg;
  logic [NREG-1:0]       busy_dbg;

  modport master (
    output id_rs, id_rs_used, id_rd, id_rw, id_ex_rs, id_ex_rd, id_ex_mem_read,
           ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw, md_issue, md_rd,
           md_done, md_done_rd, branch_taken,
    input  fwd_sel, stall, flush_id_ex, flush_if_id, stall_cycles,
           ld_cnt_dbg, busy_dbg
  );

  modport slave (
    input  id_rs, id_rs_used, id_rd, id_rw, id_ex_rs, id_ex_rd, id_ex_mem_read,
           ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw, md_issue, md_rd,
           md_done, md_done_rd, branch_taken,
    output fwd_sel, stall, flush_id_ex, flush_if_id, stall_cycles,
           ld_cnt_dbg, busy_dbg
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for the multi-cycle mul/div unit.
// One set port (issue), one clear port (writeback), NLK lookup ports.
module hazard_scoreboard #(
  parameter int AW  = 5,
  parameter int NLK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NLK*AW-1:0] lk_addr_i,
  output logic [NLK-1:0]    lk_busy_o,
  output logic [2**AW-1:0]  busy_o
);
  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first so a same-cycle set to the same register wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar j = 0; j < NLK; j++) begin : g_lk
    assign lk_busy_o[j] = busy_q[lk_addr_i[j*AW +: AW]];
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding unit: operand forward selects, load-use
// stall with configurable length, mul/div scoreboard stall, branch flush.
// Optional stall-cycle counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int AW         = HAZ_AW_DEFAULT,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_unit_if.slave  bus
);

  if (LOAD_STALL < 1 || LOAD_STALL > LOAD_STALL_MAX) begin : g_bad_load_stall
    $error("hazard_fwd_unit: LOAD_STALL must be in 1..7");
  end

  localparam logic [LD_CNT_W-1:0] LD_RELOAD = LD_CNT_W'(LOAD_STALL - 1);

  // ---------------- forwarding (EX-stage operands) ----------------
  logic [NUM_SRC-1:0] mem_hit;
  logic [NUM_SRC-1:0] wb_hit;
  logic [NUM_SRC-1:0] ld_match;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] id_rs;
    assign ex_rs = bus.id_ex_rs[k*AW +: AW];
    assign id_rs = bus.id_rs[k*AW +: AW];
    assign mem_hit[k] = bus.ex_mem_rw && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == ex_rs);
    assign wb_hit[k]  = bus.mem_wb_rw && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == ex_rs);
    assign bus.fwd_sel[2*k +: 2] = fwd_pick(mem_hit[k], wb_hit[k]);
    assign ld_match[k] = bus.id_rs_used[k] && (id_rs == bus.id_ex_rd);
  end

  // ---------------- load-use detection ----------------
  logic load_hit;
  assign load_hit = bus.id_ex_mem_read && (bus.id_ex_rd != '0) && (|ld_match);

  // ---------------- scoreboard ----------------
  logic [NUM_SRC:0] lk_busy;
  logic             sb_hit;

  hazard_scoreboard #(
    .AW  (AW),
    .NLK (NUM_SRC + 1)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (bus.md_issue),
    .set_addr_i (bus.md_rd),
    .clr_i      (bus.md_done),
    .clr_addr_i (bus.md_done_rd),
    .lk_addr_i  ({bus.id_rd, bus.id_rs}),
    .lk_busy_o  (lk_busy),
    .busy_o     (bus.busy_dbg)
  );

  // RAW on any used source, or WAW on the destination.
  assign sb_hit = (|(lk_busy[NUM_SRC-1:0] & bus.id_rs_used)) | (bus.id_rw & lk_busy[NUM_SRC]);

  // ---------------- load stall counter ----------------
  logic [LD_CNT_W-1:0] ld_cnt_q;
  logic [LD_CNT_W-1:0] ld_cnt_d;
  logic                stall;

  // The hit cycle itself stalls, the counter covers the remaining LOAD_STALL-1.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (bus.branch_taken)    ld_cnt_d = '0;
    else if (ld_cnt_q != '0) ld_cnt_d = ld_cnt_q - 1'b1;
    else if (load_hit)       ld_cnt_d = LD_RELOAD;
  end

  // Load stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_cnt_q <= '0;
    else        ld_cnt_q <= ld_cnt_d;
  end

  assign stall           = (load_hit | (ld_cnt_q != '0) | sb_hit) & ~bus.branch_taken;
  assign bus.stall       = stall;
  assign bus.flush_id_ex = stall | bus.branch_taken;
  assign bus.flush_if_id = bus.branch_taken;
  assign bus.ld_cnt_dbg  = ld_cnt_q;

  // ---------------- optional stall-cycle counter ----------------
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Saturating count of stalled cycles.
  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign bus.stall_cycles = perf_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule
